// File: rtl/dcache_ctrl_pkg.sv
// Shared memory-stage definitions for the RV32IM data cache:
// funct3 access encodings, cache FSM states and block geometry.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BLOCK_BITS  = 128;
    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_UPDATE
    } dc_state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline request/response and main-memory block bus of the dcache.
// slave: cache view; master: pipeline + main-memory view.
interface dcache_ctrl_if;
    import rv32_mem_pkg::*;

    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [31:0]           address;
    logic [31:0]           writedata;
    logic [31:0]           readdata;
    logic                  busywait;
    logic                  mm_read;
    logic                  mm_write;
    logic [27:0]           mm_address;
    logic [BLOCK_BITS-1:0] mm_writedata;
    logic [BLOCK_BITS-1:0] mm_readdata;
    logic                  mm_busywait;

    modport slave (
        input  mem_read, mem_write, funct3, address, writedata,
        input  mm_readdata, mm_busywait,
        output readdata, busywait,
        output mm_read, mm_write, mm_address, mm_writedata
    );

    modport master (
        output mem_read, mem_write, funct3, address, writedata,
        output mm_readdata, mm_busywait,
        input  readdata, busywait,
        input  mm_read, mm_write, mm_address, mm_writedata
    );

endinterface

// File: rtl/dcache_align.sv
// Load extract/extend and store byte-merge for one 32-bit cache word.
// Ports: funct3_i, byte_off_i, word_i (stored word), wdata_i -> rdata_o, wword_o.
module dcache_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wword_o
);

    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  be;
    logic [31:0] wrep;

    always_comb begin
        bsel = word_i[{byte_off_i, 3'b000} +: 8];
        hsel = word_i[{byte_off_i[1], 4'b0000} +: 16];

        rdata_o = word_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{bsel[7]}}, bsel};
            F3_BU:   rdata_o = {24'b0, bsel};
            F3_H:    rdata_o = {{16{hsel[15]}}, hsel};
            F3_HU:   rdata_o = {16'b0, hsel};
            default: rdata_o = word_i;
        endcase

        // Stores only use B/H/W; the size sits in funct3[1:0].
        be   = 4'b1111;
        wrep = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be   = 4'b0001 << byte_off_i;
                wrep = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be   = byte_off_i[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_i[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_i;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            wword_o[i*8 +: 8] = be[i] ? wrep[i*8 +: 8] : word_i[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage.
// Ports: CLK, reset (sync, active-high), bus (dcache_ctrl_if.slave);
// with DCACHE_STATS_EN defined also hit_count and miss_count outputs.
module dcache_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int NUM_LINES = 8
)
(
    input  logic        CLK,
    input  logic        reset,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    typedef logic [BLOCK_WORDS-1:0][31:0] blk_t;

    blk_t                 data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    blk_t                 fill_q;
    logic [31:0]          rdata_q;
    dc_state_e            state_q, state_d;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       woff;
    logic             req, is_wr, is_rd, hit, idle_hit;
    logic             fill_en, upd_en;
    logic [31:0]      cur_word, ld_data, st_word;

    assign req_tag  = bus.address[31 -: TAG_W];
    assign idx      = bus.address[OFFSET_W +: IDX_W];
    assign woff     = bus.address[3:2];
    assign req      = bus.mem_read | bus.mem_write;
    // Read+write together is resolved as a write.
    assign is_wr    = bus.mem_write;
    assign is_rd    = bus.mem_read & ~bus.mem_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
    assign idle_hit = (state_q == S_IDLE) && req && hit;
    assign cur_word = data_q[idx][woff];

    dcache_align u_align (
        .funct3_i   (bus.funct3),
        .byte_off_i (bus.address[1:0]),
        .word_i     (cur_word),
        .wdata_i    (bus.writedata),
        .rdata_o    (ld_data),
        .wword_o    (st_word)
    );

    always_comb begin
        state_d          = state_q;
        bus.mm_read      = 1'b0;
        bus.mm_write     = 1'b0;
        bus.mm_address   = {req_tag, idx};
        bus.mm_writedata = data_q[idx];
        fill_en          = 1'b0;
        upd_en           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ?
                              S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                bus.mm_write   = 1'b1;
                bus.mm_address = {tag_q[idx], idx};
                if (!bus.mm_busywait) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                bus.mm_read = 1'b1;
                if (!bus.mm_busywait) begin
                    fill_en = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                upd_en  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busywait = (state_q != S_IDLE) || (req && !hit);
    // Hit loads bypass the register so data arrives in the same cycle.
    assign bus.readdata = (idle_hit && is_rd) ? ld_data : rdata_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (upd_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (idle_hit && is_wr) begin
                dirty_q[idx] <= 1'b1;
            end
            if (idle_hit && is_rd) rdata_q <= ld_data;
        end
    end

    // The fetched block is captured on the completion cycle because main
    // memory need not hold mm_readdata once it drops busywait.
    always_ff @(posedge CLK) begin
        if (fill_en) fill_q <= bus.mm_readdata;
        if (upd_en) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= req_tag;
        end else if (idle_hit && is_wr) begin
            data_q[idx][woff] <= st_word;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    logic        svc_q;
    logic        miss_ev;

    assign miss_ev = (state_q == S_IDLE) && (state_d != S_IDLE);

    // svc_q marks a request whose final hit follows miss service.
    always_ff @(posedge CLK) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
            svc_q  <= 1'b0;
        end else begin
            if (miss_ev) svc_q <= 1'b1;
            else if (idle_hit) svc_q <= 1'b0;
            if (miss_ev && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
            if (idle_hit && !svc_q && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule
